apb_uart_master: RTL and testbench

- APB initiator that drives the UART core's APB slave port: baud register, TX data, status and RX data.
- A host-side command/response handshake is converted into a two-phase APB transfer (SETUP then ACCESS) that honours PREADY wait states.
- The result of each transfer (read data, or a timeout flag) is returned on a response channel.
- Sits between firmware or a test sequencer and the UART APB slave; the two share PCLK.

---
 rtl/apb_uart_master.sv | 145 ++++++++++++++
 tb/tb_apb_uart_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_master.sv
// APB initiator for the UART register block: host command/response handshake in, two-phase APB transfer out.
// Optional abort on PREADY wait timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_uart_master #(
    parameter int BITWIDTH       = 8,
    parameter int ADDR_W         = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [BITWIDTH-1:0] cmd_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [BITWIDTH-1:0] resp_rdata,
    output logic                resp_timeout,
    output logic                PSEL,
    output logic                PENABLE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PWRITE,
    output logic [BITWIDTH-1:0] PWDATA,
    input  logic [BITWIDTH-1:0] PRDATA,
    input  logic                PREADY,
    output logic                busy
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_uart_master: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [BITWIDTH-1:0] r_pwdata;
    logic                r_resp_valid;
    logic [BITWIDTH-1:0] r_resp_rdata;
    logic                r_resp_timeout;
    logic                r_busy;

    logic w_accept;
    logic w_done;
    logic w_abort;
    logic w_release;

    assign w_accept  = (r_state == S_IDLE) && cmd_valid;
    assign w_done    = (r_state == S_ACCESS) && PREADY;
    assign w_release = (r_state == S_RESP) && resp_ready;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [15:0] LIMIT_M1 = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wait_cnt;

    // Counter value after this edge would reach the limit: abort now unless PREADY wins.
    assign w_abort = (r_state == S_ACCESS) && !PREADY && (r_wait_cnt >= LIMIT_M1);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_ACCESS) && !PREADY && (r_wait_cnt != 16'hFFFF)) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (cmd_valid) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: if (PREADY || w_abort) w_state_nxt = S_RESP;
            S_RESP:   if (resp_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state        <= S_IDLE;
            r_psel         <= 1'b0;
            r_penable      <= 1'b0;
            r_pwrite       <= 1'b0;
            r_paddr        <= '0;
            r_pwdata       <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= '0;
            r_resp_timeout <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_psel       <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
            r_penable    <= (w_state_nxt == S_ACCESS);
            r_resp_valid <= (w_state_nxt == S_RESP);
            r_busy       <= (w_state_nxt != S_IDLE);

            if (w_accept) begin
                r_paddr  <= cmd_addr;
                r_pwdata <= cmd_wdata;
                r_pwrite <= cmd_write;
            end else if (w_release) begin
                r_paddr  <= '0;
                r_pwdata <= '0;
                r_pwrite <= 1'b0;
            end

            // Normal completion takes priority over a timeout on the same edge.
            if (w_done) begin
                r_resp_rdata   <= r_pwrite ? '0 : PRDATA;
                r_resp_timeout <= 1'b0;
            end else if (w_abort) begin
                r_resp_rdata   <= '0;
                r_resp_timeout <= 1'b1;
            end
        end
    end

    assign cmd_ready    = (r_state == S_IDLE);
    assign PSEL         = r_psel;
    assign PENABLE      = r_penable;
    assign PADDR        = r_paddr;
    assign PWRITE       = r_pwrite;
    assign PWDATA       = r_pwdata;
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign resp_timeout = r_resp_timeout;
    assign busy         = r_busy;

endmodule

// File: tb/tb_apb_uart_master.sv
// Self-checking bench for apb_uart_master: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_apb_uart_master;

    localparam int BW = 8;
    localparam int AW = 2;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [BW-1:0] cmd_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [BW-1:0] resp_rdata;
    logic          resp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [BW-1:0] PWDATA;
    logic [BW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          busy;

    apb_uart_master #(.BITWIDTH(BW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_timeout(resp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding command, tracked by its age and wait count.
    bit            m_active = 0;
    bit            m_done = 0;
    int            m_age = 0;
    int            m_waits = 0;
    bit            m_w = 0;
    logic [AW-1:0] m_a = '0;
    logic [BW-1:0] m_d = '0;
    logic [BW-1:0] m_rdata = '0;
    bit            m_to = 0;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_active <= 0; m_done <= 0; m_age <= 0; m_waits <= 0;
            m_w <= 0; m_a <= '0; m_d <= '0;
        end else if (!m_active) begin
            if (cmd_valid) begin
                m_active <= 1; m_done <= 0; m_age <= 1; m_waits <= 0;
                m_w <= cmd_write; m_a <= cmd_addr; m_d <= cmd_wdata;
            end
        end else if (m_done) begin
            if (resp_ready) begin
                m_active <= 0; m_done <= 0; m_w <= 0; m_a <= '0; m_d <= '0;
            end
        end else if (m_age == 1) begin
            m_age <= 2;
        end else if (PREADY) begin
            m_done <= 1; m_rdata <= m_w ? '0 : PRDATA; m_to <= 0;
        end else begin
            m_waits <= m_waits + 1;
`ifdef APB_MASTER_TIMEOUT_EN
            if (m_waits + 1 == TO) begin
                m_done <= 1; m_rdata <= '0; m_to <= 1;
            end
`endif
        end
    end

    always @(negedge PCLK) begin
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_active));
        chk("busy", 32'(busy), 32'(m_active));
        chk("psel", 32'(PSEL), 32'(m_active && !m_done));
        chk("penable", 32'(PENABLE), 32'(m_active && !m_done && m_age >= 2));
        chk("resp_valid", 32'(resp_valid), 32'(m_active && m_done));
        chk("paddr", 32'(PADDR), 32'(m_a));
        chk("pwrite", 32'(PWRITE), 32'(m_w));
        chk("pwdata", 32'(PWDATA), 32'(m_d));
        if (m_active && m_done) begin
            chk("resp_rdata", 32'(resp_rdata), 32'(m_rdata));
            chk("resp_timeout", 32'(resp_timeout), 32'(m_to));
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_prev;

        // Reset state
        repeat (3) tick();
        PRESET = 1'b0;
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);

        // Write, no wait states
        PREADY = 1'b1; resp_ready = 1'b1;
        issue(1'b1, 2'b01, 8'hA5);
        tick();
        cmd_valid = 1'b0;
        chk("wr_setup_psel", 32'(PSEL), 32'd1);
        chk("wr_setup_penable", 32'(PENABLE), 32'd0);
        chk("wr_pwdata", 32'(PWDATA), 32'hA5);
        chk("wr_pwrite", 32'(PWRITE), 32'd1);
        chk("wr_paddr", 32'(PADDR), 32'd1);
        tick();
        chk("wr_access_penable", 32'(PENABLE), 32'd1);
        tick();
        chk("wr_resp_valid", 32'(resp_valid), 32'd1);
        chk("wr_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("wr_resp_psel", 32'(PSEL), 32'd0);
        tick();
        chk("wr_next_ready", 32'(cmd_ready), 32'd1);
        chk("wr_paddr_clr", 32'(PADDR), 32'd0);

        // Read with 3 wait states
        PREADY = 1'b0;
        issue(1'b0, 2'b00, 8'h00);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rd_wait_penable", 32'(PENABLE), 32'd1);
            chk("rd_wait_paddr", 32'(PADDR), 32'd0);
        end
        PREADY = 1'b1; PRDATA = 8'h3C;
        tick();
        PRDATA = 8'h00;
        chk("rd_resp_valid", 32'(resp_valid), 32'd1);
        chk("rd_resp_rdata", 32'(resp_rdata), 32'h3C);
        chk("rd_resp_timeout", 32'(resp_timeout), 32'd0);
        chk("rd_penable_off", 32'(PENABLE), 32'd0);
        tick();

        // Response backpressure
        resp_ready = 1'b0;
        issue(1'b0, 2'b10, 8'h00);
        PRDATA = 8'h5A;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            PRDATA = 8'($urandom);
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_resp_rdata", 32'(resp_rdata), 32'h5A);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_released_ready", 32'(cmd_ready), 32'd1);

        // Back-to-back writes
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            issue(1'b1, 2'(k), 8'(8'h10 + k));
            tick();
            chk("b2b_setup_psel", 32'(PSEL), 32'd1);
            chk("b2b_setup_penable", 32'(PENABLE), 32'd0);
            chk("b2b_paddr", 32'(PADDR), 32'(k));
            chk("b2b_pwdata", 32'(PWDATA), 32'(8'h10 + k));
            if (k > 0) chk("b2b_period", 32'(cyc - t_prev), 32'd4);
            t_prev = cyc;
            tick();
            tick();
            chk("b2b_resp_valid", 32'(resp_valid), 32'd1);
            tick();
            if (k == 3) cmd_valid = 1'b0;
        end

`ifdef APB_MASTER_TIMEOUT_EN
        // Timeout abort after TO low wait cycles
        PREADY = 1'b0;
        issue(1'b0, 2'b11, 8'h00);
        PRDATA = 8'hFF;
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        chk("to_still_access", 32'(PENABLE), 32'd1);
        tick();
        chk("to_resp_valid", 32'(resp_valid), 32'd1);
        chk("to_resp_timeout", 32'(resp_timeout), 32'd1);
        chk("to_resp_rdata", 32'(resp_rdata), 32'd0);
        chk("to_psel_off", 32'(PSEL), 32'd0);
        tick();
        // PREADY rising on the limit edge completes normally
        issue(1'b0, 2'b11, 8'h00);
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        PREADY = 1'b1; PRDATA = 8'hC3;
        tick();
        chk("to_edge_timeout", 32'(resp_timeout), 32'd0);
        chk("to_edge_rdata", 32'(resp_rdata), 32'hC3);
        tick();
`endif

        // Reset in the middle of ACCESS
        PREADY = 1'b0;
        issue(1'b0, 2'b10, 8'h00);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("mid_rst_pre_psel", 32'(PSEL), 32'd1);
        #2;
        PRESET = 1'b1;
        #1;
        chk("mid_rst_psel", 32'(PSEL), 32'd0);
        chk("mid_rst_penable", 32'(PENABLE), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        PREADY = 1'b1;
        tick();
        PRESET = 1'b0;
        tick();
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_no_stale", 32'(resp_valid), 32'd0);
        end

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 800; i++) begin
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_write  = 1'($urandom_range(0, 1));
            cmd_addr   = 2'($urandom);
            cmd_wdata  = 8'($urandom);
            PRDATA     = 8'($urandom);
            PREADY     = ($urandom_range(0, 3) != 0);
            resp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        cmd_valid = 1'b0; PREADY = 1'b1; resp_ready = 1'b1;
        repeat (5) tick();
        chk("drain_idle", 32'(cmd_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
